// File: rtl/ise_pkg.sv
// -----------------------------------------------------------------------------
// ise_pkg
// Shared definitions for the frame statistics block: default pixel width and
// frame length, FSM state encoding, the per-frame result record and a helper
// that evaluates the edge flag for a min/max pair.
// -----------------------------------------------------------------------------
package ise_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int N_PIX      = 9;
   localparam int SUM_WIDTH  = DATA_WIDTH + 4;
   localparam int IDX_WIDTH  = 4;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } ise_state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] min_v;
      logic [DATA_WIDTH-1:0] max_v;
      logic [SUM_WIDTH-1:0]  sum_v;
      logic [IDX_WIDTH-1:0]  argmax_v;
      logic                  edge_v;
   } ise_rec_t;

   localparam int REC_WIDTH = $bits(ise_rec_t);

   // Unsigned spread check: max is never below min, so the difference cannot wrap.
   function automatic logic edge_exceeds(input logic [DATA_WIDTH-1:0] max_v,
                                         input logic [DATA_WIDTH-1:0] min_v,
                                         input int                    thresh);
      logic [DATA_WIDTH-1:0] diff;
      diff = max_v - min_v;
      return (int'(diff) > thresh);
   endfunction

endpackage

// File: rtl/ise_result_fifo.sv
// -----------------------------------------------------------------------------
// ise_result_fifo
// Two-entry record FIFO with read/write pointers and an occupancy count.
// A push is accepted when the FIFO is not full or when a pop happens in the
// same cycle; otherwise it is ignored (the parent reports the drop).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_rec  : push strobe and record to store
//   i_pop          : pop strobe (ignored when empty)
//   o_head         : record at the head
//   o_full/o_empty : occupancy flags
// -----------------------------------------------------------------------------
module ise_result_fifo
   import ise_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_push,
   input  logic [REC_WIDTH-1:0] i_rec,
   input  logic                 i_pop,
   output logic [REC_WIDTH-1:0] o_head,
   output logic                 o_full,
   output logic                 o_empty
);

   logic [REC_WIDTH-1:0] r_mem [0:1];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [1:0]           r_count;

   logic                 w_pop;
   logic                 w_push;

   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign o_head  = r_mem[r_rd_ptr];

   // When full, a simultaneous pop frees the slot the write pointer aims at.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   // Storage, pointer and occupancy update.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_rec;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ise_frame_stats.sv
// -----------------------------------------------------------------------------
// ise_frame_stats
// Collects N_PIX smoothed pixels per frame and produces a record with the
// frame minimum, maximum, sum, index of the first maximum and an edge flag
// (max-min above EDGE_THRESH). Records queue in a 2-entry FIFO; a gap inside
// a frame discards it with a FRAME_ERR pulse, and a record completing while
// the FIFO is full without a pop is dropped with an OVERFLOW pulse.
// Ports:
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   IN_VALID, IN_DATA     : pixel stream, no backpressure
//   OUT_READY, OUT_VALID  : record handshake, pop on VALID & READY
//   OUT_MIN/MAX/SUM/ARGMAX/EDGE : fields of the head record
//   FRAME_ERR, OVERFLOW   : one-cycle error pulses
// -----------------------------------------------------------------------------
module ise_frame_stats #(
   parameter int DATA_WIDTH  = ise_pkg::DATA_WIDTH,
   parameter int N_PIX       = ise_pkg::N_PIX,
   parameter int EDGE_THRESH = 32
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  IN_VALID,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic                  OUT_READY,
   output logic                  OUT_VALID,
   output logic [DATA_WIDTH-1:0] OUT_MIN,
   output logic [DATA_WIDTH-1:0] OUT_MAX,
   output logic [DATA_WIDTH+3:0] OUT_SUM,
   output logic [3:0]            OUT_ARGMAX,
   output logic                  OUT_EDGE,
   output logic                  FRAME_ERR,
   output logic                  OVERFLOW
);

   import ise_pkg::*;

   localparam int SUM_W = DATA_WIDTH + 4;

   ise_state_e            r_state;
   logic [3:0]            r_pcnt;
   logic [DATA_WIDTH-1:0] r_min;
   logic [DATA_WIDTH-1:0] r_max;
   logic [SUM_W-1:0]      r_sum;
   logic [3:0]            r_argmax;
   logic                  r_frame_err;
   logic                  r_overflow;

   logic                  w_first;
   logic [3:0]            w_idx;
   logic [DATA_WIDTH-1:0] w_min_n;
   logic [DATA_WIDTH-1:0] w_max_n;
   logic [SUM_W-1:0]      w_sum_n;
   logic [3:0]            w_argmax_n;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   ise_rec_t              w_rec;
   ise_rec_t              w_head;
   logic [REC_WIDTH-1:0]  w_head_bits;

   assign w_first = (r_state == ST_IDLE);

   // Running statistics including the current pixel; IDLE restarts them from it.
   always_comb begin
      w_idx      = 4'd0;
      w_min_n    = r_min;
      w_max_n    = r_max;
      w_sum_n    = r_sum;
      w_argmax_n = r_argmax;
      if (w_first) begin
         w_idx      = 4'd0;
         w_min_n    = IN_DATA;
         w_max_n    = IN_DATA;
         w_sum_n    = SUM_W'(IN_DATA);
         w_argmax_n = 4'd0;
      end else begin
         w_idx   = r_pcnt;
         w_sum_n = r_sum + SUM_W'(IN_DATA);
         if (IN_DATA < r_min) begin
            w_min_n = IN_DATA;
         end else begin
            w_min_n = r_min;
         end
         // Strict compare keeps the earliest index on ties.
         if (IN_DATA > r_max) begin
            w_max_n    = IN_DATA;
            w_argmax_n = r_pcnt;
         end else begin
            w_max_n    = r_max;
            w_argmax_n = r_argmax;
         end
      end
   end

   assign w_push = IN_VALID && (w_idx == 4'(N_PIX - 1));
   assign w_pop  = !w_empty && OUT_READY;

   // Record assembled from the values that already include the last pixel.
   always_comb begin
      w_rec          = '0;
      w_rec.min_v    = w_min_n;
      w_rec.max_v    = w_max_n;
      w_rec.sum_v    = w_sum_n;
      w_rec.argmax_v = w_argmax_n;
      w_rec.edge_v   = edge_exceeds(w_max_n, w_min_n, EDGE_THRESH);
   end

   // Frame collection FSM, accumulators and error pulses.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= ST_IDLE;
         r_pcnt      <= 4'd0;
         r_min       <= '0;
         r_max       <= '0;
         r_sum       <= '0;
         r_argmax    <= 4'd0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_overflow  <= w_push && w_full && !w_pop;
         case (r_state)
            ST_IDLE: begin
               if (IN_VALID) begin
                  r_min    <= w_min_n;
                  r_max    <= w_max_n;
                  r_sum    <= w_sum_n;
                  r_argmax <= w_argmax_n;
                  if (w_push) begin
                     r_state <= ST_IDLE;
                     r_pcnt  <= 4'd0;
                  end else begin
                     r_state <= ST_COLLECT;
                     r_pcnt  <= 4'd1;
                  end
               end else begin
                  r_state <= ST_IDLE;
                  r_pcnt  <= 4'd0;
               end
            end
            ST_COLLECT: begin
               if (IN_VALID) begin
                  r_min    <= w_min_n;
                  r_max    <= w_max_n;
                  r_sum    <= w_sum_n;
                  r_argmax <= w_argmax_n;
                  if (w_push) begin
                     r_state <= ST_IDLE;
                     r_pcnt  <= 4'd0;
                  end else begin
                     r_state <= ST_COLLECT;
                     r_pcnt  <= r_pcnt + 4'd1;
                  end
               end else begin
                  // A gap inside a frame throws the partial frame away.
                  r_frame_err <= 1'b1;
                  r_state     <= ST_IDLE;
                  r_pcnt      <= 4'd0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_pcnt  <= 4'd0;
            end
         endcase
      end
   end

   ise_result_fifo u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RESET_N),
      .i_push  (w_push),
      .i_rec   (w_rec),
      .i_pop   (w_pop),
      .o_head  (w_head_bits),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head     = ise_rec_t'(w_head_bits);
   assign OUT_VALID  = !w_empty;
   assign OUT_MIN    = w_head.min_v;
   assign OUT_MAX    = w_head.max_v;
   assign OUT_SUM    = w_head.sum_v;
   assign OUT_ARGMAX = w_head.argmax_v;
   assign OUT_EDGE   = w_head.edge_v;
   assign FRAME_ERR  = r_frame_err;
   assign OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_ise_frame_stats.sv
// -----------------------------------------------------------------------------
// tb_ise_frame_stats
// Directed frames from the requirement list followed by a randomized run
// compared against a frame/queue reference model.
// -----------------------------------------------------------------------------
module tb_ise_frame_stats;

   typedef struct {
      int mn;
      int mx;
      int sm;
      int am;
      int ed;
   } exp_t;

   logic        CLK;
   logic        RESET_N;
   logic        IN_VALID;
   logic [7:0]  IN_DATA;
   logic        OUT_READY;
   logic        OUT_VALID;
   logic [7:0]  OUT_MIN;
   logic [7:0]  OUT_MAX;
   logic [11:0] OUT_SUM;
   logic [3:0]  OUT_ARGMAX;
   logic        OUT_EDGE;
   logic        FRAME_ERR;
   logic        OVERFLOW;

   int n_err = 0;
   int n_chk = 0;
   int fe_seen = 0;
   int ov_seen = 0;

   int p1[9] = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
   int p2[9] = '{50, 50, 50, 50, 50, 50, 50, 50, 50};
   int p3[9] = '{7, 200, 3, 200, 9, 9, 9, 9, 9};
   int p4[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

   int   cur[9];
   int   k;
   int   d;
   logic v;
   logic r;
   logic do_push;
   logic do_pop;
   logic exp_fe;
   logic exp_ov;
   exp_t e;
   exp_t mq[$];

   ise_frame_stats dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .IN_VALID   (IN_VALID),
      .IN_DATA    (IN_DATA),
      .OUT_READY  (OUT_READY),
      .OUT_VALID  (OUT_VALID),
      .OUT_MIN    (OUT_MIN),
      .OUT_MAX    (OUT_MAX),
      .OUT_SUM    (OUT_SUM),
      .OUT_ARGMAX (OUT_ARGMAX),
      .OUT_EDGE   (OUT_EDGE),
      .FRAME_ERR  (FRAME_ERR),
      .OVERFLOW   (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_head(input string tag, input exp_t x);
      check({tag, ".min"},    32'(OUT_MIN),    x.mn);
      check({tag, ".max"},    32'(OUT_MAX),    x.mx);
      check({tag, ".sum"},    32'(OUT_SUM),    x.sm);
      check({tag, ".argmax"}, 32'(OUT_ARGMAX), x.am);
      check({tag, ".edge"},   32'(OUT_EDGE),   x.ed);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".valid"},  32'(OUT_VALID),  0);
      check({tag, ".min"},    32'(OUT_MIN),    0);
      check({tag, ".max"},    32'(OUT_MAX),    0);
      check({tag, ".sum"},    32'(OUT_SUM),    0);
      check({tag, ".argmax"}, 32'(OUT_ARGMAX), 0);
      check({tag, ".edge"},   32'(OUT_EDGE),   0);
      check({tag, ".ferr"},   32'(FRAME_ERR),  0);
      check({tag, ".ovf"},    32'(OVERFLOW),   0);
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (FRAME_ERR === 1'b1) fe_seen++;
      if (OVERFLOW === 1'b1) ov_seen++;
   endtask

   task automatic send_frame(input int px[9]);
      for (int i = 0; i < 9; i++) begin
         IN_VALID = 1'b1;
         IN_DATA  = 8'(px[i]);
         tick();
      end
      IN_VALID = 1'b0;
   endtask

   function automatic exp_t ref_stats(input int px[9]);
      exp_t x;
      x.mn = px[0];
      x.mx = px[0];
      x.sm = 0;
      x.am = 0;
      for (int i = 0; i < 9; i++) begin
         x.sm += px[i];
         if (px[i] < x.mn) x.mn = px[i];
         if (px[i] > x.mx) begin
            x.mx = px[i];
            x.am = i;
         end
      end
      x.ed = ((x.mx - x.mn) > 32) ? 1 : 0;
      return x;
   endfunction

   initial begin
      CLK       = 1'b0;
      RESET_N   = 1'b1;
      IN_VALID  = 1'b0;
      IN_DATA   = 8'd0;
      OUT_READY = 1'b0;
      #2 RESET_N = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      RESET_N = 1'b1;

      // Ramp 10..90, first pixel on the cycle right after reset release.
      OUT_READY = 1'b1;
      send_frame(p1);
      check("ramp.valid", 32'(OUT_VALID), 1);
      check_head("ramp", '{mn: 10, mx: 90, sm: 450, am: 8, ed: 1});
      tick();
      check("ramp.drained", 32'(OUT_VALID), 0);

      // Flat frame.
      send_frame(p2);
      check("flat.valid", 32'(OUT_VALID), 1);
      check_head("flat", '{mn: 50, mx: 50, sm: 450, am: 0, ed: 0});
      tick();

      // Tied maxima: first occurrence wins.
      send_frame(p3);
      check("tie.valid", 32'(OUT_VALID), 1);
      check_head("tie", '{mn: 3, mx: 200, sm: 455, am: 1, ed: 1});
      tick();
      check("tie.drained", 32'(OUT_VALID), 0);

      // Three back-to-back frames with the sink stalled.
      OUT_READY = 1'b0;
      ov_seen   = 0;
      send_frame(p1);
      send_frame(p2);
      send_frame(p4);
      check("ovf.pulse_now", 32'(OVERFLOW), 1);
      check("ovf.count", 32'(ov_seen), 1);
      tick();
      tick();
      check("ovf.pulse_end", 32'(OVERFLOW), 0);
      check("ovf.hold_valid", 32'(OUT_VALID), 1);
      check_head("ovf.hold", '{mn: 10, mx: 90, sm: 450, am: 8, ed: 1});
      OUT_READY = 1'b1;
      tick();
      check("ovf.second_valid", 32'(OUT_VALID), 1);
      check_head("ovf.second", '{mn: 50, mx: 50, sm: 450, am: 0, ed: 0});
      tick();
      check("ovf.empty", 32'(OUT_VALID), 0);

      // Partial frame, one-cycle gap, then a complete frame.
      fe_seen = 0;
      for (int i = 0; i < 5; i++) begin
         IN_VALID = 1'b1;
         IN_DATA  = 8'(p3[i]);
         tick();
      end
      IN_VALID = 1'b0;
      tick();
      check("gap.ferr", 32'(FRAME_ERR), 1);
      check("gap.no_record", 32'(OUT_VALID), 0);
      send_frame(p4);
      check("gap.ferr_count", 32'(fe_seen), 1);
      check("gap.valid", 32'(OUT_VALID), 1);
      check_head("gap", '{mn: 1, mx: 9, sm: 45, am: 8, ed: 0});
      tick();
      check("gap.single", 32'(OUT_VALID), 0);

      // Reset mid-frame with a record pending.
      OUT_READY = 1'b0;
      send_frame(p3);
      check("rst.pending", 32'(OUT_VALID), 1);
      for (int i = 0; i < 4; i++) begin
         IN_VALID = 1'b1;
         IN_DATA  = 8'(p1[i]);
         tick();
      end
      IN_VALID = 1'b0;
      RESET_N  = 1'b0;
      #1;
      check_all_zero("rst.async");
      fe_seen = 0;
      ov_seen = 0;
      tick();
      tick();
      RESET_N   = 1'b1;
      OUT_READY = 1'b1;
      send_frame(p1);
      check("rst.after_valid", 32'(OUT_VALID), 1);
      check_head("rst.after", '{mn: 10, mx: 90, sm: 450, am: 8, ed: 1});
      check("rst.no_ferr", 32'(fe_seen), 0);
      check("rst.no_ovf", 32'(ov_seen), 0);
      tick();
      check("rst.drained", 32'(OUT_VALID), 0);

      // Randomized traffic against the frame/queue model.
      k = 0;
      mq.delete();
      for (int c = 0; c < 600; c++) begin
         v = ($urandom_range(0, 15) != 0);
         d = int'($urandom_range(0, 255));
         if (c < 300) r = ($urandom_range(0, 3) == 0);
         else         r = ($urandom_range(0, 2) != 0);
         IN_VALID  = v;
         IN_DATA   = 8'(d);
         OUT_READY = r;
         exp_fe  = 1'b0;
         do_push = 1'b0;
         if (v) begin
            cur[k] = d;
            k++;
            if (k == 9) begin
               do_push = 1'b1;
               e       = ref_stats(cur);
               k       = 0;
            end
         end else if (k > 0) begin
            exp_fe = 1'b1;
            k      = 0;
         end
         do_pop = (mq.size() != 0) && r;
         exp_ov = do_push && (mq.size() == 2) && !do_pop;
         if (do_pop) mq.delete(0);
         if (do_push && !exp_ov) mq.push_back(e);
         tick();
         check("rnd.valid", 32'(OUT_VALID), (mq.size() != 0) ? 1 : 0);
         if (mq.size() != 0) check_head("rnd", mq[0]);
         check("rnd.ferr", 32'(FRAME_ERR), 32'(exp_fe));
         check("rnd.ovf",  32'(OVERFLOW),  32'(exp_ov));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
